// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and helpers for the memory data-port arbiter.
//   size_e    : access size codes (1B .. 16B)
//   RSP_LAT   : cycles from acceptance to response strobe
//   size_ok() : legality check of a size/address pair against the port width.
//               Despite its name it returns the ERROR condition
//               (1 = access must be rejected).
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic [2:0] {
      SZ_B = 3'd0,
      SZ_H = 3'd1,
      SZ_W = 3'd2,
      SZ_D = 3'd3,
      SZ_Q = 3'd4
   } size_e;

   localparam int RSP_LAT = 1;

   // Returns 1 when the size exceeds the port width or the address is not
   // naturally aligned to the access size.
   function automatic logic size_ok(input logic [2:0] bytes,
                                    input logic [3:0] addr_lsbs,
                                    input int         nbytes);
      logic       too_big;
      logic [4:0] mask;
      logic       misaligned;
      too_big    = (bytes > SZ_Q) || ((32'd1 << bytes) > 32'(nbytes));
      mask       = (5'd1 << bytes) - 5'd1;
      misaligned = ((addr_lsbs & mask[3:0]) != 4'd0);
      return too_big | misaligned;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin selector. The search starts at
// (last + 1) mod N and the first set bit of 'valid' wins.
//   valid [N]  : candidate requesters
//   last  [IW] : index of the previous winner
//   grant [N]  : one-hot winner (zero when nothing is valid)
//   idx   [IW] : index of the winner (0 when nothing is valid)
// -----------------------------------------------------------------------------
module rr_picker #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  valid,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx
);

   // Rotating priority search; 'found' blocks every later candidate.
   always_comb begin : pick
      int            cand;
      logic [IW-1:0] cidx;
      logic          hit;
      logic          found;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      cidx  = '0;
      hit   = 1'b0;
      for (int i = 1; i <= N; i++) begin
         cand        = (int'(last) + i) % N;
         cidx        = IW'(cand);
         hit         = ~found & valid[cidx];
         grant[cidx] = grant[cidx] | hit;
         idx         = hit ? cidx : idx;
         found       = found | hit;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single data port of the unified memory between NUM_REQ
// requesters (0 = core LSU, 1 = debug/DMA). Round-robin, one access per
// cycle, fully pipelined. Size/alignment is checked before the access is
// driven so an illegal store never writes memory. The memory answers one
// cycle after the access and the response is steered to the issuer.
//
// Optional build macro: MEM_ARB_LOCK_EN adds req_lock, letting a requester
// hold the port across several accesses (atomic read-modify-write).
//
// Ports
//   clk, rst_n        : clock, synchronous active-low reset
//   req_valid/ready   : per-requester handshake (ready is one-hot or zero)
//   req_addr/we/bytes/unsigned/wdata : per-requester access fields
//   req_lock          : (MEM_ARB_LOCK_EN only) hold the port after this access
//   rsp_valid         : per-requester one-cycle response strobe
//   rsp_rdata/rsp_err : shared response bus, qualified by rsp_valid
//   mem_*             : memory data port; mem_rd_data arrives a cycle later
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NUM_REQ = 2,
   parameter int BYTES   = WIDTH / 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0][WIDTH-1:0] req_addr,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ-1:0][2:0]       req_bytes,
   input  logic [NUM_REQ-1:0]            req_unsigned,
   input  logic [NUM_REQ-1:0][WIDTH-1:0] req_wdata,
`ifdef MEM_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]            req_lock,
`endif
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [WIDTH-1:0]              rsp_rdata,
   output logic                          rsp_err,
   output logic [WIDTH-1:0]              mem_addr,
   output logic                          mem_we,
   output logic [2:0]                    mem_bytes,
   output logic                          mem_rd_unsigned,
   output logic [WIDTH-1:0]              mem_wr_data,
   input  logic [WIDTH-1:0]              mem_rd_data
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0]   last_grant_r;
   logic               rsp_pend_r;
   logic [IDX_W-1:0]   rsp_owner_r;
   logic               rsp_err_r;
   logic               rsp_wr_r;

   logic [NUM_REQ-1:0] elig_s;
   logic [NUM_REQ-1:0] pick_s;
   logic [IDX_W-1:0]   pick_idx_s;
   logic [NUM_REQ-1:0] grant_s;
   logic               accept_s;
   logic               win_err_s;
   logic               freeze_s;

`ifdef MEM_ARB_LOCK_EN
   logic               lock_act_r;
   logic [IDX_W-1:0]   lock_owner_r;

   // While locked only the lock owner may compete for the port.
   always_comb begin
      elig_s = req_valid;
      if (lock_act_r) begin
         elig_s = req_valid & ({{(NUM_REQ-1){1'b0}}, 1'b1} << lock_owner_r);
      end else begin
         elig_s = req_valid;
      end
   end

   assign freeze_s = lock_act_r;

   // Lock state: set by a locked accept, cleared by the owner's unlocked accept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_act_r   <= 1'b0;
         lock_owner_r <= '0;
      end else if (accept_s) begin
         if (lock_act_r) begin
            lock_act_r <= req_lock[pick_idx_s];
         end else if (req_lock[pick_idx_s]) begin
            lock_act_r   <= 1'b1;
            lock_owner_r <= pick_idx_s;
         end
      end
   end
`else
   assign elig_s   = req_valid;
   assign freeze_s = 1'b0;
`endif

   rr_picker #(
      .N  (NUM_REQ),
      .IW (IDX_W)
   ) u_picker (
      .valid (elig_s),
      .last  (last_grant_r),
      .grant (pick_s),
      .idx   (pick_idx_s)
   );

   // Grant is suppressed during reset; the legality check uses the winner only.
   always_comb begin
      grant_s   = '0;
      accept_s  = 1'b0;
      win_err_s = 1'b0;
      if (rst_n) begin
         grant_s   = pick_s;
         accept_s  = |pick_s;
         win_err_s = (|pick_s) &
                     size_ok(req_bytes[pick_idx_s], req_addr[pick_idx_s][3:0], BYTES);
      end else begin
         grant_s   = '0;
         accept_s  = 1'b0;
         win_err_s = 1'b0;
      end
   end

   assign req_ready = grant_s;

   // Memory port drive: winner's fields in the accept cycle, all zero otherwise.
   always_comb begin
      mem_addr        = '0;
      mem_we          = 1'b0;
      mem_bytes       = 3'd0;
      mem_rd_unsigned = 1'b0;
      mem_wr_data     = '0;
      if (accept_s) begin
         mem_addr        = req_addr[pick_idx_s];
         mem_we          = req_we[pick_idx_s] & ~win_err_s;
         mem_bytes       = req_bytes[pick_idx_s];
         mem_rd_unsigned = req_unsigned[pick_idx_s];
         mem_wr_data     = req_wdata[pick_idx_s];
      end else begin
         mem_addr        = '0;
         mem_we          = 1'b0;
         mem_bytes       = 3'd0;
         mem_rd_unsigned = 1'b0;
         mem_wr_data     = '0;
      end
   end

   // Round-robin pointer and the single-entry response pipeline stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant_r <= IDX_W'(NUM_REQ - 1);
         rsp_pend_r   <= 1'b0;
         rsp_owner_r  <= '0;
         rsp_err_r    <= 1'b0;
         rsp_wr_r     <= 1'b0;
      end else begin
         rsp_pend_r  <= accept_s;
         rsp_owner_r <= pick_idx_s;
         rsp_err_r   <= win_err_s;
         rsp_wr_r    <= accept_s & req_we[pick_idx_s];
         if (accept_s && !freeze_s) begin
            last_grant_r <= pick_idx_s;
         end
      end
   end

   // Response steering; read data is passed only for a good load.
   always_comb begin
      rsp_valid = '0;
      rsp_err   = 1'b0;
      rsp_rdata = '0;
      if (rst_n && rsp_pend_r) begin
         rsp_valid[rsp_owner_r] = 1'b1;
         rsp_err                = rsp_err_r;
         rsp_rdata              = (!rsp_wr_r && !rsp_err_r) ? mem_rd_data : '0;
      end else begin
         rsp_valid = '0;
         rsp_err   = 1'b0;
         rsp_rdata = '0;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed, table-driven bench for mem_port_arbiter (WIDTH=32, NUM_REQ=2)
// with a small byte-addressed memory stub behind the data port. Build with
// MEM_ARB_LOCK_EN defined to also exercise the lock sequence.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int W = 32;
   localparam int N = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [N-1:0]          req_valid;
   logic [N-1:0]          req_ready;
   logic [N-1:0][W-1:0]   req_addr;
   logic [N-1:0]          req_we;
   logic [N-1:0][2:0]     req_bytes;
   logic [N-1:0]          req_unsigned;
   logic [N-1:0][W-1:0]   req_wdata;
`ifdef MEM_ARB_LOCK_EN
   logic [N-1:0]          req_lock;
`endif
   logic [N-1:0]          rsp_valid;
   logic [W-1:0]          rsp_rdata;
   logic                  rsp_err;
   logic [W-1:0]          mem_addr;
   logic                  mem_we;
   logic [2:0]            mem_bytes;
   logic                  mem_rd_unsigned;
   logic [W-1:0]          mem_wr_data;
   logic [W-1:0]          mem_rd_data;

   always #5 clk = ~clk;

   mem_port_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_addr        (req_addr),
      .req_we          (req_we),
      .req_bytes       (req_bytes),
      .req_unsigned    (req_unsigned),
      .req_wdata       (req_wdata),
`ifdef MEM_ARB_LOCK_EN
      .req_lock        (req_lock),
`endif
      .rsp_valid       (rsp_valid),
      .rsp_rdata       (rsp_rdata),
      .rsp_err         (rsp_err),
      .mem_addr        (mem_addr),
      .mem_we          (mem_we),
      .mem_bytes       (mem_bytes),
      .mem_rd_unsigned (mem_rd_unsigned),
      .mem_wr_data     (mem_wr_data),
      .mem_rd_data     (mem_rd_data)
   );

   // ---------------- memory stub (256 bytes, little-endian) ----------------
   logic [7:0] mem_b [0:255];
   logic [W-1:0] rd_next;

   function automatic logic [7:0] init_byte(input int i);
      logic [31:0] w;
      case (i / 4)
         1:       w = 32'hCAFEF00D;   // 0x04
         4:       w = 32'hAAAA5555;   // 0x10
         8:       w = 32'h12345678;   // 0x20
         default: w = 32'h0000_0000;
      endcase
      return w[8*(i%4) +: 8];
   endfunction

   // Read path with sign/zero extension, evaluated from current contents.
   always_comb begin
      logic [127:0] raw;
      logic [7:0]   a;
      int           n;
      raw     = '0;
      a       = 8'd0;
      n       = 1 << mem_bytes;
      rd_next = '0;
      for (int k = 0; k < 16; k++) begin
         a = mem_addr[7:0] + 8'(k);
         if (k < n) raw[8*k +: 8] = mem_b[a];
      end
      rd_next = raw[31:0];
      if (!mem_rd_unsigned && n < 4 && raw[8*n-1]) rd_next = rd_next | (32'hFFFF_FFFF << (8*n));
   end

   always @(posedge clk) begin
      mem_rd_data <= rd_next;
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) mem_b[i] <= init_byte(i);
      end else if (mem_we) begin
         for (int k = 0; k < 4; k++)
            if (k < (1 << mem_bytes)) mem_b[mem_addr[7:0] + 8'(k)] <= mem_wr_data[8*k +: 8];
      end
   end

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (step %0d): got %h, expected %h", nm, row, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  v;
      logic [31:0] a0, a1;
      logic        we;
      logic [2:0]  b;
      logic        u;
      logic [31:0] wd;
      logic [1:0]  e_rdy;
      logic        e_we;
      logic [31:0] e_ma;
      logic [1:0]  e_rv;
      logic        e_err;
      logic [31:0] e_rd;
   } vec_t;

   vec_t tbl [0:15];
   int   nv = 0;

   task automatic add_vec(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                          input logic we, input logic [2:0] b, input logic u, input logic [31:0] wd,
                          input logic [1:0] e_rdy, input logic e_we, input logic [31:0] e_ma,
                          input logic [1:0] e_rv, input logic e_err, input logic [31:0] e_rd);
      tbl[nv].v = v;   tbl[nv].a0 = a0; tbl[nv].a1 = a1; tbl[nv].we = we;
      tbl[nv].b = b;   tbl[nv].u = u;   tbl[nv].wd = wd;
      tbl[nv].e_rdy = e_rdy; tbl[nv].e_we = e_we; tbl[nv].e_ma = e_ma;
      tbl[nv].e_rv  = e_rv;  tbl[nv].e_err = e_err; tbl[nv].e_rd = e_rd;
      nv++;
   endtask

   task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                        input logic we, input logic [2:0] b, input logic u, input logic [31:0] wd);
      req_valid    = v;
      req_addr[0]  = a0;   req_addr[1]  = a1;
      req_we       = {we, we};
      req_bytes[0] = b;    req_bytes[1] = b;
      req_unsigned = {u, u};
      req_wdata[0] = wd;   req_wdata[1] = wd;
   endtask

   task automatic idle();
      drive(2'b00, 32'h0, 32'h0, 1'b0, 3'd0, 1'b0, 32'h0);
   endtask

   task automatic chk_acc(input int r, input logic [1:0] rdy, input logic we, input logic [31:0] ma);
      chk("req_ready", r, 32'(req_ready), 32'(rdy));
      chk("mem_we",    r, 32'(mem_we),    32'(we));
      chk("mem_addr",  r, mem_addr,       ma);
   endtask

   task automatic chk_rsp(input int r, input logic [1:0] rv, input logic err, input logic [31:0] rd);
      chk("rsp_valid", r, 32'(rsp_valid), 32'(rv));
      chk("rsp_err",   r, 32'(rsp_err),   32'(err));
      chk("rsp_rdata", r, rsp_rdata,      rd);
   endtask

   initial begin
      // valid a0 a1 we b u wd | ready we maddr | rsp_valid err rdata
      add_vec(2'b11, 32'h10,  32'h20, 1'b0, 3'd2, 1'b0, 32'h0,        2'b01, 1'b0, 32'h10,  2'b01, 1'b0, 32'hAAAA5555);
      add_vec(2'b11, 32'h10,  32'h20, 1'b0, 3'd2, 1'b0, 32'h0,        2'b10, 1'b0, 32'h20,  2'b10, 1'b0, 32'h12345678);
      add_vec(2'b11, 32'h10,  32'h20, 1'b0, 3'd2, 1'b0, 32'h0,        2'b01, 1'b0, 32'h10,  2'b01, 1'b0, 32'hAAAA5555);
      add_vec(2'b11, 32'h10,  32'h20, 1'b0, 3'd2, 1'b0, 32'h0,        2'b10, 1'b0, 32'h20,  2'b10, 1'b0, 32'h12345678);
      add_vec(2'b01, 32'h102, 32'h0,  1'b1, 3'd1, 1'b0, 32'hBEEF,     2'b01, 1'b1, 32'h102, 2'b01, 1'b0, 32'h0);
      add_vec(2'b01, 32'h102, 32'h0,  1'b0, 3'd1, 1'b0, 32'h0,        2'b01, 1'b0, 32'h102, 2'b01, 1'b0, 32'hFFFFBEEF);
      add_vec(2'b10, 32'h0,   32'h06, 1'b1, 3'd2, 1'b0, 32'hDEADBEEF, 2'b10, 1'b0, 32'h06,  2'b10, 1'b1, 32'h0);
      add_vec(2'b10, 32'h0,   32'h04, 1'b0, 3'd2, 1'b1, 32'h0,        2'b10, 1'b0, 32'h04,  2'b10, 1'b0, 32'hCAFEF00D);
      add_vec(2'b01, 32'h10,  32'h0,  1'b0, 3'd3, 1'b0, 32'h0,        2'b01, 1'b0, 32'h10,  2'b01, 1'b1, 32'h0);
      add_vec(2'b00, 32'h10,  32'h20, 1'b0, 3'd2, 1'b0, 32'h0,        2'b00, 1'b0, 32'h0,   2'b00, 1'b0, 32'h0);
      add_vec(2'b01, 32'h10,  32'h0,  1'b0, 3'd0, 1'b1, 32'h0,        2'b01, 1'b0, 32'h10,  2'b01, 1'b0, 32'h55);
      add_vec(2'b10, 32'h0,   32'h12, 1'b0, 3'd0, 1'b0, 32'h0,        2'b10, 1'b0, 32'h12,  2'b10, 1'b0, 32'hFFFFFFAA);
      add_vec(2'b11, 32'h11,  32'h20, 1'b0, 3'd1, 1'b0, 32'h0,        2'b01, 1'b0, 32'h11,  2'b01, 1'b1, 32'h0);
      add_vec(2'b11, 32'h11,  32'h20, 1'b0, 3'd1, 1'b0, 32'h0,        2'b10, 1'b0, 32'h20,  2'b10, 1'b0, 32'h00005678);
      add_vec(2'b01, 32'h30,  32'h0,  1'b1, 3'd2, 1'b0, 32'h80000001, 2'b01, 1'b1, 32'h30,  2'b01, 1'b0, 32'h0);
      add_vec(2'b01, 32'h33,  32'h0,  1'b0, 3'd0, 1'b0, 32'h0,        2'b01, 1'b0, 32'h33,  2'b01, 1'b0, 32'hFFFFFF80);

`ifdef MEM_ARB_LOCK_EN
      req_lock = 2'b00;
`endif
      // Reset with active requests: nothing may be granted or written.
      rst_n = 1'b0;
      drive(2'b11, 32'h10, 32'h20, 1'b1, 3'd2, 1'b0, 32'h11111111);
      repeat (2) @(posedge clk);
      #1;
      chk_acc(100, 2'b00, 1'b0, 32'h0);
      chk("rsp_valid", 100, 32'(rsp_valid), 32'h0);
      rst_n = 1'b1;
      idle();

      // Table: compare accept-cycle outputs, then the response a cycle later.
      for (int i = 0; i < nv; i++) begin
         @(posedge clk);
         #1;
         if (i > 0) chk_rsp(i - 1, tbl[i-1].e_rv, tbl[i-1].e_err, tbl[i-1].e_rd);
         drive(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].we, tbl[i].b, tbl[i].u, tbl[i].wd);
         #2;
         chk_acc(i, tbl[i].e_rdy, tbl[i].e_we, tbl[i].e_ma);
      end
      @(posedge clk);
      #1;
      chk_rsp(nv - 1, tbl[nv-1].e_rv, tbl[nv-1].e_err, tbl[nv-1].e_rd);

      // Reset right after a load acceptance: response dropped, pointer reset.
      drive(2'b10, 32'h0, 32'h20, 1'b0, 3'd2, 1'b0, 32'h0);
      #2;
      chk_acc(200, 2'b10, 1'b0, 32'h20);
      @(posedge clk);
      #1;
      chk_rsp(200, 2'b10, 1'b0, 32'h12345678);
      drive(2'b01, 32'h10, 32'h0, 1'b0, 3'd2, 1'b0, 32'h0);
      #2;
      chk_acc(201, 2'b01, 1'b0, 32'h10);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      drive(2'b11, 32'h10, 32'h20, 1'b1, 3'd2, 1'b0, 32'h22222222);
      #2;
      chk("rsp_valid", 202, 32'(rsp_valid), 32'h0);
      chk_acc(202, 2'b00, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(2'b11, 32'h10, 32'h20, 1'b0, 3'd2, 1'b0, 32'h0);
      #2;
      chk("rsp_valid", 203, 32'(rsp_valid), 32'h0);
      chk_acc(203, 2'b01, 1'b0, 32'h10);
      @(posedge clk);
      #1;
      chk_rsp(203, 2'b01, 1'b0, 32'hAAAA5555);

`ifdef MEM_ARB_LOCK_EN
      // req1 locks the port; req0 stays valid but waits for the unlock store.
      drive(2'b11, 32'h10, 32'h20, 1'b0, 3'd2, 1'b0, 32'h0);
      req_lock = 2'b10;
      #2;
      chk_acc(300, 2'b10, 1'b0, 32'h20);
      @(posedge clk);
      #1;
      chk_rsp(300, 2'b10, 1'b0, 32'h12345678);
      #2;
      chk_acc(301, 2'b10, 1'b0, 32'h20);
      @(posedge clk);
      #1;
      drive(2'b11, 32'h10, 32'h20, 1'b0, 3'd2, 1'b0, 32'h0);
      req_we     = 2'b10;
      req_lock   = 2'b00;
      #2;
      chk_acc(302, 2'b10, 1'b1, 32'h20);
      @(posedge clk);
      #1;
      req_we = 2'b00;
      chk_rsp(302, 2'b10, 1'b0, 32'h0);
      #2;
      chk_acc(303, 2'b01, 1'b0, 32'h10);
      @(posedge clk);
      #1;
`endif
      idle();
      @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data port of the unified memory manager between NUM_REQ requesters (core LSU = 0, debug/DMA master = 1).
- Round-robin grant; at most one access per cycle; fully pipelined.
- Pre-checks size/alignment so illegal stores never reach memory.
- Routes the 1-cycle-latency response back to the requester that issued the access.

Parameters:
- WIDTH, 32, data/address width; multiple of 8, at most 128.
- NUM_REQ, 2, number of requesters; at least 2.
- BYTES, WIDTH/8, bytes per memory word (derived; do not override).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NUM_REQ  request valid per requester
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- req_addr  in  NUM_REQ x WIDTH  byte address
- req_we  in  NUM_REQ  1 = store, 0 = load
- req_bytes  in  NUM_REQ x 3  size code: 0=1B, 1=2B, 2=4B, 3=8B, 4=16B
- req_unsigned  in  NUM_REQ  load zero-extends
- req_wdata  in  NUM_REQ x WIDTH  store data, right-aligned
- rsp_valid  out  NUM_REQ  response strobe, one cycle
- rsp_rdata  out  WIDTH  load data; shared bus, qualified by rsp_valid
- rsp_err  out  1  access rejected; qualified by rsp_valid
- mem_addr  out  WIDTH  to memory data port
- mem_we  out  1  memory write enable
- mem_bytes  out  3  size code
- mem_rd_unsigned  out  1  sign/zero-extend select
- mem_wr_data  out  WIDTH  write data
- mem_rd_data  in  WIDTH  read data, valid the cycle after the access

Behaviour:
- Synchronous reset (rst_n low at posedge):
  - last_grant <= NUM_REQ-1, so requester 0 wins first.
  - Pending response cleared.
  - While rst_n is low, req_ready = 0 and mem_we = 0.
- Grant (combinational, same cycle):
  - Search valid requesters starting at (last_grant+1) mod NUM_REQ; the first hit gets req_ready = 1.
  - last_grant updates on acceptance only.
  - Ready never depends on the response state, so back-to-back accepts occur every cycle.
- Error check on the winner:
  - err = bytes > log2(BYTES), or addr[bytes-1:0] != 0 (bytes > 0).
  - Applies to loads and stores alike.
- Memory drive in the accept cycle:
  - mem_addr/bytes/rd_unsigned/wr_data take the winner's fields.
  - mem_we = winner.we & ~err.
  - No grant: all mem outputs 0.
- Response register: rsp_pend, rsp_owner, rsp_err, rsp_wr, loaded at every posedge from the accept cycle.
  - The cycle after acceptance: rsp_valid[rsp_owner] = 1, rsp_err = rsp_err.
  - rsp_rdata = mem_rd_data for a good load, otherwise 0.
  - Stores and errored accesses still produce a response (ack).
  - No response backpressure: requesters must sink rsp_valid.
- Latency: exactly 1 cycle from acceptance to response; throughput 1 access per cycle.
- Simultaneous events:
  - A response for access N and the acceptance of N+1 in the same cycle are independent.
  - The same requester may have both in one cycle.
- Invalid-then-valid: a requester dropping valid without acceptance is legal and leaves no state.
- Reset mid-operation: a response pending at the reset edge is discarded (rsp_valid = 0 next cycle).

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- With the macro defined:
  - Adds input req_lock [NUM_REQ].
  - Accepting a request with req_lock = 1 sets lock_owner; while locked, only lock_owner is eligible.
  - Others see ready = 0 and last_grant is frozen.
  - Lock clears when lock_owner has an accepted request with req_lock = 0, or on reset.
  - Used for atomic read-modify-write.
- Without the macro: no req_lock port and no lock state; pure round-robin.

Decomposition:
- Package mem_arb_pkg:
  - size_e enum (SZ_B=0, SZ_H=1, SZ_W=2, SZ_D=3, SZ_Q=4).
  - Function size_ok(bytes, addr_lsbs, BYTES) returning the error condition.
  - Localparam RSP_LAT = 1.
- Sub-module rr_picker #(N):
  - Inputs: valid vector, last pointer.
  - Outputs: one-hot grant and index.
  - Purely combinational; reusable by later masters.

Test Plan:
- Reset, then both valid, word loads at 0x10 (req0) and 0x20 (req1), held 4 cycles, memory preloaded 0xAAAA5555 / 0x12345678:
  - Grants alternate 0,1,0,1.
  - rsp_valid alternates one cycle later.
  - rsp_rdata = 0xAAAA5555, 0x12345678 repeating.
- req0 store, bytes=1, addr 0x102, wdata 0xBEEF; next cycle load, bytes=1, unsigned=0:
  - Store ack rsp_err = 0.
  - Load returns 0xFFFFBEEF.
- req1 store, bytes=2, addr 0x06:
  - mem_we = 0 in the accept cycle; rsp_err = 1 next cycle.
  - A following load from 0x04 shows the old data unchanged.
- req0 load, bytes=3 with WIDTH=32:
  - rsp_err = 1, rsp_rdata = 0.
- rst_n low in the cycle after accepting a load:
  - No rsp_valid.
  - After release, the first grant goes to requester 0 even if requester 1 won last.
- MEM_ARB_LOCK_EN: req1 load with lock=1 while req0 stays valid:
  - req0 gets no grant until req1 completes its store with lock=0.
  - req0 is granted the next cycle.
